// File: rtl/dct8_mac_engine.sv
// dct8_mac_engine
//   1-D 8-point DCT-II of one 8-sample row held in a pixel EBR. The row is
//   fetched into a sample register file, then a single signed MAC walks a
//   64-entry coefficient ROM (k outer, n inner). Each finished coefficient
//   is rounded, saturated and written back at {base, k}.
//
// Ports
//   clock, reset          : clock, asynchronous active-high reset
//   start, level_shift,
//   block_base            : transform request; level_shift/base latched with start
//   busy, done            : busy while transforming, done pulses one cycle at the end
//   fetch_addr/data/clk   : row buffer EBR read port (1-cycle read latency)
//   result_out/addr/wren/
//   result_clk            : coefficient EBR write port
module dct8_mac_engine #(
  parameter int IN_WIDTH   = 8,
  parameter int OUT_WIDTH  = 16,
  parameter int COEF_FRAC  = 12,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  level_shift,
  input  logic [ADDR_WIDTH-4:0] block_base,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic [IN_WIDTH-1:0]   fetch_data,
  output logic                  fetch_clk,
  output logic [OUT_WIDTH-1:0]  result_out,
  output logic [ADDR_WIDTH-1:0] result_addr,
  output logic                  result_wren,
  output logic                  result_clk
);

  localparam int SW = IN_WIDTH + 1;               // converted sample width
  localparam int CW = COEF_FRAC + 2;              // coefficient width
  localparam int PW = SW + CW;                    // product width
  localparam int AW = IN_WIDTH + COEF_FRAC + 6;   // accumulator width
  localparam int BW = ADDR_WIDTH - 3;             // base address width

  localparam logic [AW:0] RND_HALF = (AW + 1)'(1) << (COEF_FRAC - 1);
  localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_MAC,
    S_FLUSH,
    S_DONE
  } state_t;

  // 0.5*cos(m*pi/16) scaled by 2^30, m = 0..8. C[k][n] folds onto this
  // table by symmetry and is then rounded half-away to COEF_FRAC bits.
  function automatic logic signed [CW-1:0] coef_val(input int k, input int n);
    int  a;
    int  v;
    int  r;
    bit  neg;
    a = ((2 * n + 1) * k) % 32;
    if (a > 16) a = 32 - a;
    neg = (a > 8);
    if (neg) a = 16 - a;
    if (k == 0) a = 4;                            // c(0)/2 == cos(pi/4)/2
    case (a)
      0:       v = 536870912;
      1:       v = 526555088;
      2:       v = 496004047;
      3:       v = 446391849;
      4:       v = 379625062;
      5:       v = 298269498;
      6:       v = 205451603;
      7:       v = 104738319;
      default: v = 0;
    endcase
    r = (v + (1 << (29 - COEF_FRAC))) >>> (30 - COEF_FRAC);
    if (neg) r = -r;
    return CW'(r);
  endfunction

  logic signed [CW-1:0] rom [64];
  for (genvar gi = 0; gi < 64; gi++) begin : g_rom
    assign rom[gi] = coef_val(gi / 8, gi % 8);
  end

  state_t                 state_q, state_d;
  logic [5:0]             cnt_q, cnt_d;
  logic [BW-1:0]          base_q, base_d;
  logic                   ls_q, ls_d;
  logic signed [SW-1:0]   x_q [8];
  logic signed [SW-1:0]   x_d [8];
  logic signed [AW-1:0]   acc_q, acc_d;
  logic [OUT_WIDTH-1:0]   res_q, res_d;
  logic [ADDR_WIDTH-1:0]  res_addr_q, res_addr_d;
  logic                   wren_q, wren_d;

  logic                   samp_msb;
  logic signed [SW-1:0]   samp;
  logic [2:0]             k_idx;
  logic [2:0]             n_idx;
  logic signed [PW-1:0]   prod;
  logic signed [AW-1:0]   acc_sum;
  logic signed [AW:0]     rnd;
  logic signed [AW:0]     shifted;
  logic [AW-OUT_WIDTH+1:0] hi_bits;
  logic [OUT_WIDTH-1:0]   sat_val;

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      base_q     <= '0;
      ls_q       <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) x_q[i] <= '0;
      acc_q      <= '0;
      res_q      <= '0;
      res_addr_q <= '0;
      wren_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      ls_q       <= ls_d;
      for (int unsigned i = 0; i < 8; i++) x_q[i] <= x_d[i];
      acc_q      <= acc_d;
      res_q      <= res_d;
      res_addr_q <= res_addr_d;
      wren_q     <= wren_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd7) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        state_d = S_MAC;
        cnt_d   = '0;
      end
      S_MAC: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd63) state_d = S_FLUSH;
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy        = (state_q == S_FETCH) || (state_q == S_DRAIN) ||
                  (state_q == S_MAC)   || (state_q == S_FLUSH);
    done        = (state_q == S_DONE);
    fetch_addr  = (state_q == S_FETCH) ? {base_q, cnt_q[2:0]} : '0;
    fetch_clk   = clock;
    result_out  = res_q;
    result_addr = res_addr_q;
    result_wren = wren_q;
    result_clk  = clock;
  end

  // Datapath
  always_comb begin
    base_d = base_q;
    ls_d   = ls_q;
    if (state_q == S_IDLE && start) begin
      base_d = block_base;
      ls_d   = level_shift;
    end

    // Subtracting 2^(IN_WIDTH-1) from an unsigned sample is the same as
    // flipping its MSB and reading it as signed; then sign-extend by one.
    samp_msb = fetch_data[IN_WIDTH-1] ^ ls_q;
    samp     = {samp_msb, samp_msb, fetch_data[IN_WIDTH-2:0]};

    // Samples shift in at x[7]; after eight captures x[0] holds sample 0.
    for (int unsigned i = 0; i < 8; i++) x_d[i] = x_q[i];
    if ((state_q == S_FETCH && cnt_q != 6'd0) || state_q == S_DRAIN) begin
      for (int unsigned i = 0; i < 7; i++) x_d[i] = x_q[i+1];
      x_d[7] = samp;
    end

    k_idx   = cnt_q[5:3];
    n_idx   = cnt_q[2:0];
    prod    = x_q[n_idx] * rom[cnt_q];
    acc_sum = ((n_idx == 3'd0) ? '0 : acc_q) + AW'(prod);
    acc_d   = (state_q == S_MAC) ? acc_sum : acc_q;

    rnd     = {acc_sum[AW-1], acc_sum} + RND_HALF;
    shifted = rnd >>> COEF_FRAC;
    hi_bits = shifted[AW:OUT_WIDTH-1];
    if ((&hi_bits) || !(|hi_bits)) sat_val = shifted[OUT_WIDTH-1:0];
    else                           sat_val = shifted[AW] ? OUT_MIN : OUT_MAX;

    // The finished sum of row k is registered on its last product, so the
    // write overlaps the first product of row k+1.
    res_d      = res_q;
    res_addr_d = res_addr_q;
    wren_d     = 1'b0;
    if (state_q == S_MAC && n_idx == 3'd7) begin
      res_d      = sat_val;
      res_addr_d = {base_q, k_idx};
      wren_d     = 1'b1;
    end
  end

endmodule

// File: tb/tb_dct8_mac_engine.sv
module tb_dct8_mac_engine;

  localparam int  IW  = 8;
  localparam int  CF  = 12;
  localparam int  ADW = 9;
  localparam int  OW  = 16;
  localparam int  OW8 = 8;
  localparam int  NC  = 90;
  localparam real PI  = 3.14159265358979323846;

  logic           clk, rst, start, level_shift;
  logic [ADW-4:0] block_base;
  logic [IW-1:0]  fetch_data, fetch_data8;
  logic           busy, done, fetch_clk, result_wren, result_clk;
  logic [ADW-1:0] fetch_addr, result_addr;
  logic [OW-1:0]  result_out;
  logic           busy8, done8, fetch_clk8, result_wren8, result_clk8;
  logic [ADW-1:0] fetch_addr8, result_addr8;
  logic [OW8-1:0] result_out8;

  dct8_mac_engine #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .COEF_FRAC(CF), .ADDR_WIDTH(ADW)) u_dut (
    .clock(clk), .reset(rst), .start(start), .level_shift(level_shift),
    .block_base(block_base), .busy(busy), .done(done), .fetch_addr(fetch_addr),
    .fetch_data(fetch_data), .fetch_clk(fetch_clk), .result_out(result_out),
    .result_addr(result_addr), .result_wren(result_wren), .result_clk(result_clk)
  );

  dct8_mac_engine #(.IN_WIDTH(IW), .OUT_WIDTH(OW8), .COEF_FRAC(CF), .ADDR_WIDTH(ADW)) u_dut8 (
    .clock(clk), .reset(rst), .start(start), .level_shift(level_shift),
    .block_base(block_base), .busy(busy8), .done(done8), .fetch_addr(fetch_addr8),
    .fetch_data(fetch_data8), .fetch_clk(fetch_clk8), .result_out(result_out8),
    .result_addr(result_addr8), .result_wren(result_wren8), .result_clk(result_clk8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row buffer EBR with one cycle of read latency, one read port per DUT
  logic [IW-1:0] mem [1 << ADW];
  always @(posedge clk) begin
    fetch_data  <= mem[fetch_addr];
    fetch_data8 <= mem[fetch_addr8];
  end

  int total = 0;
  int bad   = 0;

  logic [IW-1:0]         cur_samp [8];
  logic [OW-1:0]         exp16 [8];
  logic [OW8-1:0]        exp8  [8];

  logic                  r_busy  [NC+1];
  logic                  r_done  [NC+1];
  logic                  r_wren  [NC+1];
  logic [ADW-1:0]        r_waddr [NC+1];
  logic [OW-1:0]         r_wdata [NC+1];
  logic [ADW-1:0]        r_faddr [NC+1];
  logic                  r_wren8 [NC+1];
  logic [ADW-1:0]        r_waddr8[NC+1];
  logic [OW8-1:0]        r_wdata8[NC+1];

  // ---------------- reference model ----------------
  function automatic int coef_ref(input int k, input int n);
    real ck, v;
    ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
    v  = 0.5 * ck * $cos(real'((2 * n + 1) * k) * PI / 16.0) * real'(1 << CF);
    if (v >= 0.0) return $rtoi($floor(v + 0.5));
    else          return -$rtoi($floor(-v + 0.5));
  endfunction

  task automatic model_compute(input bit lsv);
    longint acc, r, r16, r8;
    int     xv;
    for (int unsigned k = 0; k < 8; k++) begin
      acc = 0;
      for (int unsigned n = 0; n < 8; n++) begin
        xv  = lsv ? int'(cur_samp[n]) - (1 << (IW - 1)) : int'($signed(cur_samp[n]));
        acc = acc + longint'(xv) * longint'(coef_ref(int'(k), int'(n)));
      end
      r   = (acc + (longint'(1) << (CF - 1))) >>> CF;
      r16 = (r > 32767) ? 32767 : ((r < -32768) ? -32768 : r);
      r8  = (r > 127) ? 127 : ((r < -128) ? -128 : r);
      exp16[k] = OW'(r16);
      exp8[k]  = OW8'(r8);
    end
  endtask

  task automatic load_block(input logic [ADW-4:0] b);
    for (int unsigned n = 0; n < 8; n++) mem[{b, n[2:0]}] = cur_samp[n];
  endtask

  task automatic random_samples();
    for (int unsigned n = 0; n < 8; n++) cur_samp[n] = IW'($urandom);
  endtask

  // Start one transform and record the outputs seen in cycles 1..NC.
  // start stays high through cycle 'hold'; base/level_shift are scrambled
  // after acceptance.
  task automatic run_transform(input logic [ADW-4:0] b, input bit lsv, input int hold);
    @(negedge clk);
    block_base  = b;
    level_shift = lsv;
    start       = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= NC; c++) begin
      @(negedge clk);
      r_busy[c]   = busy;
      r_done[c]   = done;
      r_wren[c]   = result_wren;
      r_waddr[c]  = result_addr;
      r_wdata[c]  = result_out;
      r_faddr[c]  = fetch_addr;
      r_wren8[c]  = result_wren8;
      r_waddr8[c] = result_addr8;
      r_wdata8[c] = result_out8;
      start       = (c <= hold);
      block_base  = (ADW - 3)'($urandom);
      level_shift = 1'($urandom);
    end
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; level_shift = 1'b0; block_base = '0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (result_wren !== 1'b0) begin bad++; $display("FAIL reset_wren: got %b want 0", result_wren); end
    total++; if (fetch_addr !== '0) begin bad++; $display("FAIL reset_faddr: got %0d want 0", fetch_addr); end
    total++; if (result_addr !== '0) begin bad++; $display("FAIL reset_raddr: got %0d want 0", result_addr); end
    total++; if (result_out !== '0) begin bad++; $display("FAIL reset_rout: got %0h want 0", result_out); end
    total++; if (result_out8 !== '0 || busy8 !== 1'b0) begin bad++; $display("FAIL reset_dut8: got out=%0h busy=%b want 0 0", result_out8, busy8); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0 || result_wren !== 1'b0) begin bad++; $display("FAIL idle_after_reset: got busy=%b wren=%b want 0 0", busy, result_wren); end
  endtask

  task automatic test_constant_100();
    for (int unsigned n = 0; n < 8; n++) cur_samp[n] = 8'd100;
    load_block('0);
    run_transform('0, 1'b0, 0);
    total++; if (r_wdata[18] !== 16'h011B || r_waddr[18] !== 9'd0) begin bad++; $display("FAIL const100_x0: got %0h@%0d want 011b@0", r_wdata[18], r_waddr[18]); end
    for (int unsigned k = 1; k < 8; k++) begin
      total++;
      if (r_wdata[18+8*k] !== 16'h0000 || r_waddr[18+8*k] !== ADW'(k)) begin
        bad++; $display("FAIL const100_x%0d: got %0h@%0d want 0@%0d", k, r_wdata[18+8*k], r_waddr[18+8*k], k);
      end
    end
    for (int c = 1; c <= NC; c++) begin
      total++;
      if (r_busy[c] !== (c <= 74) || r_done[c] !== (c == 75)) begin
        bad++; $display("FAIL const100_handshake c=%0d: got busy=%b done=%b want %b %b", c, r_busy[c], r_done[c], (c <= 74), (c == 75));
      end
    end
  endtask

  task automatic test_level_shift_zero();
    for (int unsigned n = 0; n < 8; n++) cur_samp[n] = 8'h00;
    load_block(6'd3);
    run_transform(6'd3, 1'b1, 0);
    total++; if (r_wdata[18] !== 16'hFE96) begin bad++; $display("FAIL ls_zero_x0: got %0h want fe96", r_wdata[18]); end
    for (int unsigned k = 1; k < 8; k++) begin
      total++;
      if (r_wdata[18+8*k] !== 16'h0000 || r_waddr[18+8*k] !== {6'd3, k[2:0]}) begin
        bad++; $display("FAIL ls_zero_x%0d: got %0h@%0d want 0@%0d", k, r_wdata[18+8*k], r_waddr[18+8*k], 24 + k);
      end
    end
  endtask

  task automatic test_impulse();
    int nw;
    for (int unsigned n = 0; n < 8; n++) cur_samp[n] = 8'd0;
    cur_samp[0] = 8'd64;
    load_block(6'd1);
    model_compute(1'b0);
    run_transform(6'd1, 1'b0, 0);
    total++; if (r_wdata[18] !== 16'd23) begin bad++; $display("FAIL impulse_x0: got %0d want 23", r_wdata[18]); end
    total++; if (r_wdata[26] !== 16'd31) begin bad++; $display("FAIL impulse_x1: got %0d want 31", r_wdata[26]); end
    total++; if (r_wdata[50] !== 16'd23) begin bad++; $display("FAIL impulse_x4: got %0d want 23", r_wdata[50]); end
    nw = 0;
    for (int c = 1; c <= NC; c++) begin
      if (c >= 18 && c <= 74 && ((c - 18) % 8) == 0) begin
        total++;
        if (r_wren[c] !== 1'b1 || r_wdata[c] !== exp16[(c-18)/8]) begin
          bad++; $display("FAIL impulse_write c=%0d: got wren=%b data=%0h want 1 %0h", c, r_wren[c], r_wdata[c], exp16[(c-18)/8]);
        end
      end else if (r_wren[c] !== 1'b0) nw++;
    end
    total++; if (nw !== 0) begin bad++; $display("FAIL impulse_stray_writes: got %0d want 0", nw); end
  endtask

  task automatic test_saturation();
    for (int unsigned n = 0; n < 8; n++) cur_samp[n] = 8'd127;
    load_block(6'd7);
    model_compute(1'b0);
    run_transform(6'd7, 1'b0, 0);
    total++; if (r_wdata8[18] !== 8'h7F) begin bad++; $display("FAIL sat8_x0: got %0h want 7f", r_wdata8[18]); end
    total++; if (r_wdata[18] !== exp16[0]) begin bad++; $display("FAIL sat16_x0: got %0h want %0h", r_wdata[18], exp16[0]); end
    for (int unsigned k = 1; k < 8; k++) begin
      total++;
      if (r_wdata8[18+8*k] !== 8'h00 || r_wren8[18+8*k] !== 1'b1) begin
        bad++; $display("FAIL sat8_x%0d: got %0h wren=%b want 0 1", k, r_wdata8[18+8*k], r_wren8[18+8*k]);
      end
    end
  endtask

  task automatic test_start_ignored();
    int nw, nd;
    random_samples();
    load_block(6'd5);
    model_compute(1'b1);
    run_transform(6'd5, 1'b1, 75);
    nw = 0; nd = 0;
    for (int c = 1; c <= NC; c++) begin
      if (c <= 8) begin
        total++;
        if (r_faddr[c] !== ADW'(40 + c - 1)) begin bad++; $display("FAIL restart_faddr c=%0d: got %0d want %0d", c, r_faddr[c], 40 + c - 1); end
      end
      if (r_wren[c] === 1'b1) begin
        nw++;
        total++;
        if (r_waddr[c] < 40 || r_waddr[c] > 47 || r_wdata[c] !== exp16[r_waddr[c][2:0]]) begin
          bad++; $display("FAIL restart_write c=%0d: got %0h@%0d want %0h@40..47", c, r_wdata[c], r_waddr[c], exp16[r_waddr[c][2:0]]);
        end
      end
      if (r_done[c] === 1'b1) nd++;
      if (c >= 76) begin
        total++;
        if (r_busy[c] !== 1'b0) begin bad++; $display("FAIL restart_busy c=%0d: got %b want 0", c, r_busy[c]); end
      end
    end
    total++; if (nw !== 8) begin bad++; $display("FAIL restart_write_count: got %0d want 8", nw); end
    total++; if (nd !== 1) begin bad++; $display("FAIL restart_done_count: got %0d want 1", nd); end
  endtask

  task automatic test_reset_mid();
    int nw;
    random_samples();
    load_block(6'd2);
    @(negedge clk);
    block_base = 6'd2; level_shift = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c < 30; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0 || result_wren !== 1'b0) begin bad++; $display("FAIL midreset_ctrl: got busy=%b done=%b wren=%b want 0 0 0", busy, done, result_wren); end
    total++; if (fetch_addr !== '0 || result_addr !== '0 || result_out !== '0) begin bad++; $display("FAIL midreset_data: got fa=%0d ra=%0d ro=%0h want 0 0 0", fetch_addr, result_addr, result_out); end
    total++; if (busy8 !== 1'b0 || result_out8 !== '0) begin bad++; $display("FAIL midreset_dut8: got busy=%b ro=%0h want 0 0", busy8, result_out8); end
    nw = 0;
    for (int c = 31; c <= 80; c++) begin
      @(negedge clk);
      if (c == 32) rst = 1'b0;
      if (result_wren !== 1'b0 || busy !== 1'b0 || result_wren8 !== 1'b0) nw++;
    end
    total++; if (nw !== 0) begin bad++; $display("FAIL midreset_activity: got %0d active cycles want 0", nw); end
    random_samples();
    load_block(6'd4);
    model_compute(1'b0);
    run_transform(6'd4, 1'b0, 0);
    for (int unsigned k = 0; k < 8; k++) begin
      total++;
      if (r_wdata[18+8*k] !== exp16[k] || r_waddr[18+8*k] !== {6'd4, k[2:0]}) begin
        bad++; $display("FAIL postreset_x%0d: got %0h@%0d want %0h@%0d", k, r_wdata[18+8*k], r_waddr[18+8*k], exp16[k], 32 + k);
      end
    end
  endtask

  task automatic test_random();
    logic [ADW-4:0] b;
    bit             lsv;
    int             nw;
    for (int unsigned it = 0; it < 8; it++) begin
      random_samples();
      b   = (ADW - 3)'($urandom);
      lsv = 1'($urandom);
      load_block(b);
      model_compute(lsv);
      run_transform(b, lsv, 0);
      nw = 0;
      for (int unsigned k = 0; k < 8; k++) begin
        total++;
        if (r_wren[18+8*k] !== 1'b1 || r_wdata[18+8*k] !== exp16[k] || r_waddr[18+8*k] !== {b, k[2:0]}) begin
          bad++; $display("FAIL rand%0d_x%0d: got %0h@%0d want %0h@%0d", it, k, r_wdata[18+8*k], r_waddr[18+8*k], exp16[k], {b, k[2:0]});
        end
        total++;
        if (r_wren8[18+8*k] !== 1'b1 || r_wdata8[18+8*k] !== exp8[k] || r_waddr8[18+8*k] !== {b, k[2:0]}) begin
          bad++; $display("FAIL rand%0d_sat_x%0d: got %0h want %0h", it, k, r_wdata8[18+8*k], exp8[k]);
        end
      end
      for (int c = 1; c <= NC; c++) if (r_wren[c] === 1'b1) nw++;
      total++; if (nw !== 8) begin bad++; $display("FAIL rand%0d_write_count: got %0d want 8", it, nw); end
    end
  endtask

  initial begin
    for (int unsigned i = 0; i < (1 << ADW); i++) mem[i] = IW'($urandom);
    test_reset();
    test_constant_100();
    test_level_shift_zero();
    test_impulse();
    test_saturation();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
